// File: rtl/gate_sweep_ctrl.sv
// Built-in self-test sequencer for the 3-bit-select two-input gate unit.
// Walks all 32 {sel,a,b} vectors, captures the unit's output and scores it against the golden table.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        unit_out,
  output logic        a_o,
  output logic        b_o,
  output logic [2:0]  sel_o,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_o,
  output logic        mismatch,
  output logic [5:0]  err_count,
  output logic [7:0]  fail_sel
);

  localparam int unsigned    CW          = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [31:0]    EXP         = 32'h3396_1E87;
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   table_q, table_d;
  logic          mismatch_q, mismatch_d;
  logic [5:0]    err_q, err_d;
  logic [7:0]    fail_q, fail_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      table_q    <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      table_q    <= table_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    table_d    = table_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    fail_d     = fail_q;
    unique case (state_q)
      IDLE: begin
        // Results survive in IDLE so software can read them until the next sweep.
        if (start) begin
          table_d    = '0;
          mismatch_d = 1'b0;
          err_d      = '0;
          fail_d     = '0;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[idx_q] = unit_out;
        if (unit_out != EXP[idx_q]) begin
          err_d               = err_q + 6'd1;
          mismatch_d          = 1'b1;
          fail_d[idx_q[4:2]]  = 1'b1;
        end
        if (idx_q == 5'd31) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The vector index register drives the unit directly, so no output decode glitches.
  assign {sel_o, a_o, b_o} = idx_q;
  assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign table_o   = table_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign fail_sel  = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: a behavioural gate unit with injectable faults
// feeds two controllers (SETTLE=1 and SETTLE=3); final results are scoreboarded per sweep.
module tb_gate_sweep_ctrl;

  typedef struct {
    logic [31:0] tbl;
    logic [5:0]  err;
    logic        mism;
    logic [7:0]  fail;
    int          doneCycle;
  } expRes_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startReq = 1'b0;
  logic useBig = 1'b0;
  int   unitMode = 0;

  logic start1, start3, unitOut1, unitOut3;
  logic a1, b1, busy1, done1, mism1;
  logic a3, b3, busy3, done3, mism3;
  logic [2:0]  sel1, sel3;
  logic [31:0] tbl1, tbl3;
  logic [5:0]  err1, err3;
  logic [7:0]  fail1, fail3;

  int nCompared = 0;
  int nMismatched = 0;
  expRes_t sbq[$];

  always #5 clk = ~clk;

  // Independent behavioural gate unit; mode 1 = output stuck at 0, mode 2 = sel3 behaves as OR.
  function automatic logic gateModel(input int mode, input logic [4:0] v);
    logic a, b, r;
    a = v[1];
    b = v[0];
    case (v[4:2])
      3'd0: r = ~(a & b);
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = (mode == 2) ? (a | b) : ~(a | b);
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      default: r = ~a;
    endcase
    if (mode == 1) r = 1'b0;
    return r;
  endfunction

  function automatic expRes_t predict(input int mode, input int doneCycle);
    expRes_t e;
    logic [31:0] golden, diff;
    golden = 32'h3396_1E87;
    e.tbl = '0;
    for (int i = 0; i < 32; i++) e.tbl[i] = gateModel(mode, 5'(i));
    diff   = e.tbl ^ golden;
    e.err  = '0;
    e.fail = '0;
    for (int i = 0; i < 32; i++) e.err += 6'(diff[i]);
    for (int k = 0; k < 8; k++) e.fail[k] = |diff[k*4 +: 4];
    e.mism = |diff;
    e.doneCycle = doneCycle;
    return e;
  endfunction

  assign start1   = startReq & ~useBig;
  assign start3   = startReq & useBig;
  assign unitOut1 = gateModel(unitMode, {sel1, a1, b1});
  assign unitOut3 = gateModel(unitMode, {sel3, a3, b3});

  gate_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .unit_out(unitOut1),
    .a_o(a1), .b_o(b1), .sel_o(sel1), .busy(busy1), .done(done1),
    .table_o(tbl1), .mismatch(mism1), .err_count(err1), .fail_sel(fail1)
  );

  gate_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .unit_out(unitOut3),
    .a_o(a3), .b_o(b3), .sel_o(sel3), .busy(busy3), .done(done3),
    .table_o(tbl3), .mismatch(mism3), .err_count(err3), .fail_sel(fail3)
  );

  wire        obsBusy  = useBig ? busy3 : busy1;
  wire        obsDone  = useBig ? done3 : done1;
  wire [4:0]  obsDrive = useBig ? {sel3, a3, b3} : {sel1, a1, b1};
  wire [31:0] obsTbl   = useBig ? tbl3 : tbl1;
  wire [5:0]  obsErr   = useBig ? err3 : err1;
  wire        obsMism  = useBig ? mism3 : mism1;
  wire [7:0]  obsFail  = useBig ? fail3 : fail1;
  wire [53:0] allOut1  = {a1, b1, sel1, busy1, done1, tbl1, mism1, err1, fail1};
  wire [53:0] allOut3  = {a3, b3, sel3, busy3, done3, tbl3, mism3, err3, fail3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sweep; start is re-asserted during cycle restartAt (0 = never).
  task automatic run_sweep(input int mode, input logic big, input int restartAt);
    int per, doneAt, seenDone, busyErr, driveErr;
    expRes_t e;
    per      = big ? 4 : 2;
    doneAt   = 32 * per + 1;
    seenDone = 0;
    busyErr  = 0;
    driveErr = 0;
    unitMode = mode;
    useBig   = big;
    sbq.push_back(predict(mode, doneAt));
    startReq = 1'b1;
    tick();
    startReq = 1'b0;
    for (int c = 1; c <= doneAt + 1; c++) begin
      if (obsBusy !== (c < doneAt)) busyErr++;
      if (c < doneAt && obsDrive !== 5'((c - 1) / per)) driveErr++;
      if (obsDone === 1'b1) begin
        seenDone++;
        if (seenDone == 1 && sbq.size() > 0) begin
          e = sbq.pop_front();
          nCompared += 5;
          if (c !== e.doneCycle) begin
            nMismatched++;
            $display("[TB] FAIL doneCycle mode=%0d got %0d want %0d", mode, c, e.doneCycle);
          end
          if (obsTbl !== e.tbl) begin
            nMismatched++;
            $display("[TB] FAIL table mode=%0d got %h want %h", mode, obsTbl, e.tbl);
          end
          if (obsErr !== e.err) begin
            nMismatched++;
            $display("[TB] FAIL errCount mode=%0d got %0d want %0d", mode, obsErr, e.err);
          end
          if (obsMism !== e.mism) begin
            nMismatched++;
            $display("[TB] FAIL mismatchFlag mode=%0d got %b want %b", mode, obsMism, e.mism);
          end
          if (obsFail !== e.fail) begin
            nMismatched++;
            $display("[TB] FAIL failSel mode=%0d got %h want %h", mode, obsFail, e.fail);
          end
        end
      end
      startReq = (c == restartAt);
      tick();
    end
    startReq = 1'b0;
    if (seenDone == 0 && sbq.size() > 0) void'(sbq.pop_front());
    nCompared += 3;
    if (seenDone !== 1) begin
      nMismatched++;
      $display("[TB] FAIL donePulses mode=%0d got %0d want 1", mode, seenDone);
    end
    if (busyErr !== 0) begin
      nMismatched++;
      $display("[TB] FAIL busyProfile mode=%0d got %0d bad cycles want 0", mode, busyErr);
    end
    if (driveErr !== 0) begin
      nMismatched++;
      $display("[TB] FAIL driveWalk mode=%0d got %0d bad cycles want 0", mode, driveErr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    nCompared += 2;
    if (allOut1 !== 54'd0) begin
      nMismatched++;
      $display("[TB] FAIL resetState1 got %h want 0", allOut1);
    end
    if (allOut3 !== 54'd0) begin
      nMismatched++;
      $display("[TB] FAIL resetState3 got %h want 0", allOut3);
    end
  endtask

  task automatic test_golden();
    logic [31:0] goldenLit;
    goldenLit = 32'h3396_1E87;
    run_sweep(0, 1'b0, 0);
    nCompared++;
    if (tbl1 !== goldenLit) begin
      nMismatched++;
      $display("[TB] FAIL goldenHold got %h want %h", tbl1, goldenLit);
    end
  endtask

  task automatic test_stuck_zero();
    run_sweep(1, 1'b0, 0);
  endtask

  task automatic test_sel3_fault();
    run_sweep(2, 1'b0, 0);
  endtask

  task automatic test_settle3();
    run_sweep(0, 1'b1, 0);
  endtask

  task automatic test_start_ignored();
    run_sweep(0, 1'b0, 20);
  endtask

  task automatic test_back_to_back();
    run_sweep(1, 1'b0, 65);
    run_sweep(0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_sweep();
    int doneSeen;
    doneSeen = 0;
    unitMode = 1;
    useBig   = 1'b0;
    startReq = 1'b1;
    tick();
    startReq = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nCompared++;
    if (allOut1 !== 54'd0) begin
      nMismatched++;
      $display("[TB] FAIL abortState got %h want 0", allOut1);
    end
    repeat (80) begin
      if (done1 === 1'b1) doneSeen++;
      tick();
    end
    nCompared++;
    if (doneSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL abortDone got %0d pulses want 0", doneSeen);
    end
    run_sweep(0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck_zero();
    test_sel3_fault();
    test_settle3();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
